// File: rtl/clkdiv_calib_ctrl.sv
// Power-up and phase-alignment sequencer for a CLKDIV divider: waits for stable PLL lock, pulses the
// divider reset, lets the divided clock settle, then steps the phase with CALIB pulses until align_ok.
module clkdiv_calib_ctrl #(
    parameter logic [15:0] LOCK_CYC   = 16'd64,
    parameter logic [15:0] RST_CYC    = 16'd16,
    parameter logic [15:0] SETTLE_CYC = 16'd32,
    parameter logic [15:0] CAL_W      = 16'd2,
    parameter logic [15:0] WAIT_CYC   = 16'd40,
    parameter logic [3:0]  MAX_TRY    = 4'd5,
    parameter logic        AUTO_ALIGN = 1'b1
) (
    input  logic       hclkin,
    input  logic       resetn,
    input  logic       pll_lock,
    input  logic       calib_req,
    input  logic       align_ok,
    output logic       div_resetn,
    output logic       div_calib,
    output logic       ready,
    output logic       busy,
    output logic       align_done,
    output logic       align_fail,
    output logic [3:0] try_cnt
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        RST_HOLD  = 3'd1,
        SETTLE    = 3'd2,
        READY     = 3'd3,
        CHECK     = 3'd4,
        CAL_PULSE = 3'd5,
        CAL_WAIT  = 3'd6
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        lk_meta_reg, lk_reg;
    logic [3:0]  try_cnt_reg, try_cnt_next;
    logic        align_done_reg, align_done_next;
    logic        align_fail_reg, align_fail_next;
    logic        div_resetn_reg, div_resetn_next;
    logic        div_calib_reg, div_calib_next;
    logic        ready_reg, ready_next;
    logic        busy_reg, busy_next;

    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            lk_meta_reg <= 1'b0;
            lk_reg      <= 1'b0;
        end else begin
            lk_meta_reg <= pll_lock;
            lk_reg      <= lk_meta_reg;
        end
    end

    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= WAIT_LOCK;
            cnt_reg        <= 16'd0;
            try_cnt_reg    <= 4'd0;
            align_done_reg <= 1'b0;
            align_fail_reg <= 1'b0;
            div_resetn_reg <= 1'b0;
            div_calib_reg  <= 1'b0;
            ready_reg      <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            try_cnt_reg    <= try_cnt_next;
            align_done_reg <= align_done_next;
            align_fail_reg <= align_fail_next;
            div_resetn_reg <= div_resetn_next;
            div_calib_reg  <= div_calib_next;
            ready_reg      <= ready_next;
            busy_reg       <= busy_next;
        end
    end

    // Lock loss overrides every other transition, including a pending calib_req.
    always_comb begin
        state_next = state_reg;
        if (state_reg != WAIT_LOCK && !lk_reg) begin
            state_next = WAIT_LOCK;
        end else begin
            case (state_reg)
                WAIT_LOCK: if (lk_reg && cnt_reg == LOCK_CYC - 16'd1) state_next = RST_HOLD;
                RST_HOLD:  if (cnt_reg == RST_CYC - 16'd1) state_next = SETTLE;
                SETTLE: begin
                    if (cnt_reg == SETTLE_CYC - 16'd1) begin
                        if (AUTO_ALIGN) state_next = CHECK;
                        else            state_next = READY;
                    end
                end
                READY:     if (calib_req) state_next = CHECK;
                CHECK: begin
                    if (align_ok || try_cnt_reg == MAX_TRY) state_next = READY;
                    else                                    state_next = CAL_PULSE;
                end
                CAL_PULSE: if (cnt_reg == CAL_W - 16'd1) state_next = CAL_WAIT;
                CAL_WAIT:  if (cnt_reg == WAIT_CYC - 16'd1) state_next = CHECK;
                default:   state_next = WAIT_LOCK;
            endcase
        end

        // Dwell counter restarts on every state entry and on any lk=0 cycle while waiting for lock.
        cnt_next = cnt_reg;
        if (state_next != state_reg || (state_reg == WAIT_LOCK && !lk_reg))
            cnt_next = 16'd0;
        else if (cnt_reg != 16'hFFFF)
            cnt_next = cnt_reg + 16'd1;
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        div_resetn_next = !(state_next == WAIT_LOCK || state_next == RST_HOLD);
        div_calib_next  = (state_next == CAL_PULSE);
        ready_next      = (state_next == READY);
        busy_next       = (state_next == CHECK || state_next == CAL_PULSE || state_next == CAL_WAIT);
        align_done_next = align_done_reg;
        align_fail_next = align_fail_reg;
        try_cnt_next    = try_cnt_reg;
        if (state_next == WAIT_LOCK ||
            (state_next == CHECK && (state_reg == READY || state_reg == SETTLE))) begin
            align_done_next = 1'b0;
            align_fail_next = 1'b0;
            try_cnt_next    = 4'd0;
        end else if (state_reg == CHECK) begin
            if (state_next == READY) begin
                if (align_ok) align_done_next = 1'b1;
                else          align_fail_next = 1'b1;
            end else if (state_next == CAL_PULSE) begin
                try_cnt_next = try_cnt_reg + 4'd1;
            end
        end
    end

    assign div_resetn = div_resetn_reg;
    assign div_calib  = div_calib_reg;
    assign ready      = ready_reg;
    assign busy       = busy_reg;
    assign align_done = align_done_reg;
    assign align_fail = align_fail_reg;
    assign try_cnt    = try_cnt_reg;

endmodule
